// File: rtl/rrarbiter.sv
// Round-robin ownership arbiter: grants one of N requesters and holds the grant until Done or abandon.
// Latency: one cycle from Req (in IDLE) or from a release event to the new registered grant.
// Backpressure: the owner holds off all other requesters; Done or dropping its Req hands off on the same edge.
module rrarbiter #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [N-1:0] Req,
    input  logic         Done,
    output logic [N-1:0] Grant,
    output logic [W-1:0] GrantIdx,
    output logic         GrantValid
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t         state;
    logic [W-1:0]   ptr;

    // Scan inputs and results
    logic [W-1:0]   next_ptr;
    logic [W-1:0]   scan_start;
    logic [N-1:0]   scan_req;
    logic [N-1:0]   scan_rot;
    logic [W-1:0]   scan_ofs;
    logic [W:0]     scan_sum;
    logic           found;
    logic [W-1:0]   found_idx;
    logic [N-1:0]   grant_nxt;
    logic           owner_req;
    logic           rel;

    // Release detection and the pointer value that follows the current owner (wraps N-1 -> 0)
    always_comb begin
        owner_req = |(Req & Grant);
        rel       = (state == OWNED) && (Done || !owner_req);
        next_ptr  = (GrantIdx == W'(N - 1)) ? '0 : GrantIdx + W'(1);
    end

    // Rotating first-set scan: in IDLE start at ptr over all requests; on release start just past
    // the owner and exclude the owner so it cannot be re-granted on the releasing edge
    always_comb begin
        scan_start = ptr;
        scan_req   = Req;
        if (state == OWNED) begin
            scan_start = next_ptr;
            scan_req   = Req & ~Grant;
        end
        // Rotate right by scan_start so bit 0 of scan_rot corresponds to index scan_start
        scan_rot = N'({scan_req, scan_req} >> scan_start);
        found    = 1'b0;
        scan_ofs = '0;
        for (int j = 0; j < N; j++) begin
            if (!found && scan_rot[j]) begin
                found    = 1'b1;
                scan_ofs = W'(j);
            end
        end
        // Map the rotated offset back to an absolute index modulo N
        scan_sum = {1'b0, scan_start} + {1'b0, scan_ofs};
        if (scan_sum >= (W + 1)'(N)) begin
            scan_sum = scan_sum - (W + 1)'(N);
        end
        found_idx = scan_sum[W-1:0];
        grant_nxt = {{(N - 1){1'b0}}, 1'b1} << found_idx;
    end

    // Ownership FSM with registered grant outputs and the rotating pointer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            ptr        <= '0;
            Grant      <= '0;
            GrantIdx   <= '0;
            GrantValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state      <= OWNED;
                        Grant      <= grant_nxt;
                        GrantIdx   <= found_idx;
                        GrantValid <= 1'b1;
                    end
                end
                OWNED: begin
                    if (rel) begin
                        ptr <= next_ptr;
                        if (found) begin
                            Grant      <= grant_nxt;
                            GrantIdx   <= found_idx;
                            GrantValid <= 1'b1;
                        end else begin
                            state      <= IDLE;
                            Grant      <= '0;
                            GrantIdx   <= '0;
                            GrantValid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    Grant      <= '0;
                    GrantIdx   <= '0;
                    GrantValid <= 1'b0;
                end
            endcase
        end
    end

    // Structural invariants of the grant outputs
    a_onehot: assert property (@(posedge clk) disable iff (!resetn) $onehot0(Grant));
    a_valid:  assert property (@(posedge clk) disable iff (!resetn) GrantValid == (|Grant));
    a_index:  assert property (@(posedge clk) disable iff (!resetn)
                               GrantValid |-> (Grant == ({{(N - 1){1'b0}}, 1'b1} << GrantIdx)));
    a_range:  assert property (@(posedge clk) disable iff (!resetn) GrantIdx <= W'(N - 1));

endmodule

// File: tb/tb_rrarbiter.sv
module tb_rrarbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic [3:0] req4;
    logic       done4;
    logic [3:0] grant4;
    logic [1:0] idx4;
    logic       vld4;
    logic [4:0] req5;
    logic       done5;
    logic [4:0] grant5;
    logic [2:0] idx5;
    logic       vld5;

    rrarbiter #(.N(4)) u_dut4 (
        .clk(clk), .resetn(resetn), .Req(req4), .Done(done4),
        .Grant(grant4), .GrantIdx(idx4), .GrantValid(vld4)
    );

    rrarbiter #(.N(5)) u_dut5 (
        .clk(clk), .resetn(resetn), .Req(req5), .Done(done5),
        .Grant(grant5), .GrantIdx(idx5), .GrantValid(vld5)
    );

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] i;
        logic       v;
    } exp4_t;

    typedef struct packed {
        logic [4:0] g;
        logic [2:0] i;
        logic       v;
    } exp5_t;

    exp4_t sb4[$];
    exp5_t sb5[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic exp4_t mk4(input int idx);
        exp4_t e;
        e = '0;
        if (idx >= 0) begin
            e.g = 4'b0001 << idx;
            e.i = idx[1:0];
            e.v = 1'b1;
        end
        return e;
    endfunction

    function automatic exp5_t mk5(input int idx);
        exp5_t e;
        e = '0;
        if (idx >= 0) begin
            e.g = 5'b00001 << idx;
            e.i = idx[2:0];
            e.v = 1'b1;
        end
        return e;
    endfunction

    task automatic tick4(input logic [3:0] r, input logic d);
        req4  = r;
        done4 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic tick5(input logic [4:0] r, input logic d);
        req5  = r;
        done5 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req4   = '0;
        done4  = 1'b0;
        req5   = '0;
        done5  = 1'b0;
        resetn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp4_t got4;
        exp5_t got5;
        resetn = 1'b0;
        req4   = 4'b1111;
        done4  = 1'b0;
        req5   = 5'b11111;
        done5  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        got4 = {grant4, idx4, vld4};
        n_checks++;
        if (got4 !== mk4(-1)) begin
            n_fail++;
            $display("FAIL reset_n4: got %b, want %b", got4, mk4(-1));
        end
        got5 = {grant5, idx5, vld5};
        n_checks++;
        if (got5 !== mk5(-1)) begin
            n_fail++;
            $display("FAIL reset_n5: got %b, want %b", got5, mk5(-1));
        end
        do_reset();
    endtask

    task automatic test_basic();
        logic [3:0] rq [6] = '{4'b0100, 4'b0111, 4'b0000, 4'b0000, 4'b1111, 4'b1111};
        logic       dn [6] = '{1'b0,    1'b0,    1'b1,    1'b1,    1'b0,    1'b0};
        int         ex [6] = '{2,       2,       -1,      -1,      3,       3};
        exp4_t got, want;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            sb4.push_back(mk4(ex[k]));
            tick4(rq[k], dn[k]);
            got  = {grant4, idx4, vld4};
            want = sb4.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL basic[%0d]: got grant=%b idx=%0d vld=%b, want grant=%b idx=%0d vld=%b",
                         k, got.g, got.i, got.v, want.g, want.i, want.v);
            end
        end
    endtask

    task automatic test_rotation();
        logic dn [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int   ex [6] = '{0,    1,    2,    3,    0,    1};
        exp4_t got, want;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            sb4.push_back(mk4(ex[k]));
            tick4(4'b1111, dn[k]);
            got  = {grant4, idx4, vld4};
            want = sb4.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL rotation[%0d]: got grant=%b idx=%0d vld=%b, want grant=%b idx=%0d vld=%b",
                         k, got.g, got.i, got.v, want.g, want.i, want.v);
            end
        end
    endtask

    task automatic test_no_regrant();
        logic dn [3] = '{1'b0, 1'b1, 1'b0};
        int   ex [3] = '{1,    -1,   1};
        exp4_t got, want;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            sb4.push_back(mk4(ex[k]));
            tick4(4'b0010, dn[k]);
            got  = {grant4, idx4, vld4};
            want = sb4.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL no_regrant[%0d]: got grant=%b idx=%0d vld=%b, want grant=%b idx=%0d vld=%b",
                         k, got.g, got.i, got.v, want.g, want.i, want.v);
            end
        end
    endtask

    task automatic test_abandon();
        logic [3:0] rq [5] = '{4'b1000, 4'b0001, 4'b1111, 4'b1111, 4'b0100};
        logic       dn [5] = '{1'b0,    1'b0,    1'b1,    1'b0,    1'b1};
        int         ex [5] = '{3,       0,       1,       1,       2};
        exp4_t got, want;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            sb4.push_back(mk4(ex[k]));
            tick4(rq[k], dn[k]);
            got  = {grant4, idx4, vld4};
            want = sb4.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL abandon[%0d]: got grant=%b idx=%0d vld=%b, want grant=%b idx=%0d vld=%b",
                         k, got.g, got.i, got.v, want.g, want.i, want.v);
            end
        end
    endtask

    task automatic test_async_reset();
        exp4_t got, want;
        do_reset();
        sb4.push_back(mk4(2));
        tick4(4'b0100, 1'b0);
        got  = {grant4, idx4, vld4};
        want = sb4.pop_front();
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async_pre: got %b, want %b", got, want);
        end
        #2;
        resetn = 1'b0;
        #1;
        got = {grant4, idx4, vld4};
        n_checks++;
        if (got !== mk4(-1)) begin
            n_fail++;
            $display("FAIL async_drop: got %b, want %b", got, mk4(-1));
        end
        #1;
        resetn = 1'b1;
        sb4.push_back(mk4(0));
        tick4(4'b1111, 1'b0);
        got  = {grant4, idx4, vld4};
        want = sb4.pop_front();
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async_restart: got %b, want %b", got, want);
        end
    endtask

    function automatic int first_from(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic test_random();
        int         owner = -1;
        int         mptr  = 0;
        logic [3:0] r, rm;
        logic       d;
        exp4_t      got, want;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            r = 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 2) == 0);
            if (owner < 0) begin
                if (r != 4'b0000) owner = first_from(r, mptr);
            end else if (d || !r[owner]) begin
                mptr      = (owner + 1) % 4;
                rm        = r;
                rm[owner] = 1'b0;
                owner     = first_from(rm, mptr);
            end
            sb4.push_back(mk4(owner));
            tick4(r, d);
            got  = {grant4, idx4, vld4};
            want = sb4.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL random[%0d] req=%b done=%b: got grant=%b idx=%0d vld=%b, want grant=%b idx=%0d vld=%b",
                         k, r, d, got.g, got.i, got.v, want.g, want.i, want.v);
            end
        end
    endtask

    task automatic test_nonpow2();
        logic [4:0] rq [12] = '{5'b01000, 5'b00000, 5'b00001, 5'b00000, 5'b11111, 5'b11111,
                                5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b01000, 5'b10001};
        logic       dn [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int         ex [12] = '{3, -1, 0, -1, 1, 2, 3, 4, 0, 1, 3, 4};
        exp5_t got, want;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            sb5.push_back(mk5(ex[k]));
            tick5(rq[k], dn[k]);
            got  = {grant5, idx5, vld5};
            want = sb5.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL nonpow2[%0d]: got grant=%b idx=%0d vld=%b, want grant=%b idx=%0d vld=%b",
                         k, got.g, got.i, got.v, want.g, want.i, want.v);
            end
            n_checks++;
            if (idx5 > 3'd4) begin
                n_fail++;
                $display("FAIL nonpow2_range[%0d]: got idx=%0d, want <= 4", k, idx5);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rotation();
        test_no_regrant();
        test_abandon();
        test_async_reset();
        test_random();
        test_nonpow2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rrarbiter.md
RRARBITER -- requirements
Module: rrarbiter

Interface
REQ-001 SHALL have parameter N, default 8, number of requesters; legal range 2..64, any value including non-powers of 2.
REQ-002 SHALL have localparam W = $clog2(N), the index width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port Req  input  N  request vector; bit i high means requester i wants ownership.
REQ-006 SHALL have port Done  input  1  the current owner releases the grant; ignored when GrantValid is low.
REQ-007 SHALL have port Grant  output  N  registered one-hot grant; all zero when no owner.
REQ-008 SHALL have port GrantIdx  output  W  registered binary index of the granted requester; 0 when no owner.
REQ-009 SHALL have port GrantValid  output  1  registered; high when Grant is nonzero.

Function
REQ-010 SHALL keep internal state: FSM {IDLE, OWNED}, W-bit rotating pointer Ptr, and registered Grant/GrantIdx.
REQ-011 SHALL, in IDLE with Req nonzero, select the first set Req bit scanning Ptr, Ptr+1, ..., N-1, 0, ..., Ptr-1 (wrap modulo N), and enter OWNED with that grant visible on the next edge.
REQ-012 SHALL use one cycle of latency from Req rising in IDLE to GrantValid high.
REQ-013 SHALL, in IDLE with Req all zero, stay in IDLE with outputs zero and Ptr unchanged.
REQ-014 SHALL, in OWNED, hold Grant, GrantIdx and GrantValid stable while Done is low and Req[GrantIdx] is high, regardless of other Req bits.
REQ-015 SHALL treat a release event as Done high, or Req[GrantIdx] low (abandon), in OWNED; both in the same cycle count as one release.
REQ-016 SHALL, on a release event, set Ptr to GrantIdx+1 modulo N (N-1 wraps to 0).
REQ-017 SHALL, on a release event with any Req bit set other than the releasing index, grant the next requester by the REQ-011 scan from the new Ptr on the same edge. This is a back-to-back handoff with no idle cycle, and the FSM stays OWNED.
REQ-018 SHALL, on a release event with no other Req bit set, return to IDLE with Grant=0, GrantIdx=0 and GrantValid=0 on the next edge; the releasing requester SHALL NOT be re-granted on that edge even if its Req stays high.
REQ-019 SHALL guarantee that Grant is always zero or exactly one-hot, with Grant[GrantIdx]=1 whenever GrantValid=1.
REQ-020 SHALL guarantee starvation freedom: with all N requesters continuously requesting, each is granted exactly once per N consecutive grants, in ascending index order with wrap.
REQ-021 SHALL ignore Done in IDLE, with no state or Ptr change.
REQ-022 SHALL compute all scan logic combinationally from Req and Ptr; no multicycle paths.

Reset
REQ-023 SHALL, while resetn is low and independent of clk, force state=IDLE, Ptr=0, Grant=0, GrantIdx=0 and GrantValid=0.
REQ-024 SHALL, when reset asserts mid-ownership, drop the grant immediately; after resetn deasserts, arbitration restarts from Ptr=0 on the first rising edge.

Verification
REQ-025 SHALL cover basic grant and release (N=4): Req=0100 in IDLE -> next cycle Grant=0100, GrantIdx=2, GrantValid=1. Then Done pulse with Req=0000 -> next cycle all zero and Ptr=3.
REQ-026 SHALL cover rotation and wrap (N=4, all requesting): Req=1111 held, Done pulsed each cycle after grant -> GrantIdx sequence 0,1,2,3,0 with no gaps between grants.
REQ-027 SHALL cover no self re-grant: after a grant to idx 1 (Ptr=0), Req=0010 held, Done pulsed -> next cycle GrantValid=0, then the following cycle GrantIdx=1 again.
REQ-028 SHALL cover abandon: owner idx 3 (N=4), Req drops 1000->0001 with Done low -> next edge Grant=0001, GrantIdx=0, Ptr=0.
REQ-029 SHALL cover non-power-of-2 N: N=5, Ptr=4, Req=00001 -> GrantIdx=0 (wrap), GrantIdx never exceeds 4.
REQ-030 SHALL cover async reset: resetn pulled low between clock edges while GrantValid=1 -> outputs go to 0 before the next rising edge; after release, Req=1111 -> GrantIdx=0.
